// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - plant-side phase timer answering the washing-machine controller
// Debounces level/temperature switches, times wash/rinse/spin and flags fill/heat time-outs.
module wm_phase_timer #(
  parameter int CNT_W          = 16,
  parameter int DEB_CYCLES     = 4,
  parameter int WASH_CYCLES    = 1000,
  parameter int RINSE_CYCLES   = 600,
  parameter int SPIN_CYCLES    = 400,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_fill_Water_Operation,
  input  logic       i_heat_Water_Operation,
  input  logic       i_wash_Operation,
  input  logic       i_rinse_Operation,
  input  logic       i_spin_Operation,
  input  logic       i_level_Raw,
  input  logic       i_temp_Raw,
  output logic       o_sig_Full,
  output logic       o_sig_Temperature,
  output logic       o_sig_Completed,
  output logic       o_sig_Time_Out,
  output logic       o_op_Conflict,
  output logic [2:0] o_phase
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_HEAT      = 3'd2,
    S_WASH      = 3'd3,
    S_RINSE     = 3'd4,
    S_SPIN      = 3'd5,
    S_DONE      = 3'd6,
    S_TIMED_OUT = 3'd7
  } state_t;

  // Terminal counts are compared against the pre-increment value, so the pulse
  // register loads on the edge where the full count is reached.
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_CYCLES - 1);

  state_t           r_state;
  state_t           r_last_op;
  state_t           w_sel;
  state_t           w_state_nx;
  state_t           w_last_op_nx;
  logic [CNT_W-1:0] r_phase_cnt;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] w_phase_cnt_nx;
  logic [CNT_W-1:0] w_deb_cnt_nx;
  logic [CNT_W-1:0] w_phase_cnt_inc;
  logic [CNT_W-1:0] w_dur_last;
  logic [4:0]       w_ops;
  logic             w_conflict;
  logic             w_raw;
  logic             w_success;
  logic             r_full;
  logic             r_temp;
  logic             r_completed;
  logic             r_time_out;
  logic             r_conflict;
  logic             w_full_nx;
  logic             w_temp_nx;
  logic             w_completed_nx;
  logic             w_time_out_nx;

  assign w_ops = {i_spin_Operation, i_rinse_Operation, i_wash_Operation,
                  i_heat_Water_Operation, i_fill_Water_Operation};

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign w_conflict = (w_ops & (w_ops - 5'd1)) != 5'd0;

  always_comb begin
    w_sel = S_IDLE;
    if (i_fill_Water_Operation)      w_sel = S_FILL;
    else if (i_heat_Water_Operation) w_sel = S_HEAT;
    else if (i_wash_Operation)       w_sel = S_WASH;
    else if (i_rinse_Operation)      w_sel = S_RINSE;
    else if (i_spin_Operation)       w_sel = S_SPIN;
  end

  assign w_phase_cnt_inc = (r_phase_cnt == {CNT_W{1'b1}}) ? r_phase_cnt
                                                          : r_phase_cnt + CNT_W'(1);

  always_comb begin
    w_dur_last = WASH_LAST;
    case (r_state)
      S_RINSE: w_dur_last = RINSE_LAST;
      S_SPIN:  w_dur_last = SPIN_LAST;
      default: w_dur_last = WASH_LAST;
    endcase
  end

  assign w_raw = (r_state == S_FILL) ? i_level_Raw : i_temp_Raw;

  always_comb begin
    w_state_nx     = r_state;
    w_last_op_nx   = r_last_op;
    w_phase_cnt_nx = r_phase_cnt;
    w_deb_cnt_nx   = r_deb_cnt;
    w_full_nx      = 1'b0;
    w_temp_nx      = 1'b0;
    w_completed_nx = 1'b0;
    w_time_out_nx  = 1'b0;
    w_success      = 1'b0;

    // A change of selected operation (including dropping to none) always wins
    // and aborts whatever the current phase was doing.
    if (w_sel != r_last_op) begin
      w_state_nx     = w_sel;
      w_last_op_nx   = w_sel;
      w_phase_cnt_nx = '0;
      w_deb_cnt_nx   = '0;
    end else begin
      case (r_state)
        S_FILL, S_HEAT: begin
          w_phase_cnt_nx = w_phase_cnt_inc;
          if (w_raw) begin
            if (r_deb_cnt == DEB_LAST) w_success = 1'b1;
            else                       w_deb_cnt_nx = r_deb_cnt + CNT_W'(1);
          end else begin
            w_deb_cnt_nx = '0;
          end
          if (w_success) begin
            w_state_nx = S_DONE;
            w_full_nx  = (r_state == S_FILL);
            w_temp_nx  = (r_state == S_HEAT);
          end else if (r_phase_cnt == TO_LAST) begin
            w_state_nx    = S_TIMED_OUT;
            w_time_out_nx = 1'b1;
          end
        end
        S_WASH, S_RINSE, S_SPIN: begin
          w_phase_cnt_nx = w_phase_cnt_inc;
          if (r_phase_cnt == w_dur_last) begin
            w_state_nx     = S_DONE;
            w_completed_nx = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_last_op   <= S_IDLE;
      r_phase_cnt <= '0;
      r_deb_cnt   <= '0;
      r_full      <= 1'b0;
      r_temp      <= 1'b0;
      r_completed <= 1'b0;
      r_time_out  <= 1'b0;
      r_conflict  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_last_op   <= w_last_op_nx;
      r_phase_cnt <= w_phase_cnt_nx;
      r_deb_cnt   <= w_deb_cnt_nx;
      r_full      <= w_full_nx;
      r_temp      <= w_temp_nx;
      r_completed <= w_completed_nx;
      r_time_out  <= w_time_out_nx;
      r_conflict  <= w_conflict;
    end
  end

  assign o_sig_Full        = r_full;
  assign o_sig_Temperature = r_temp;
  assign o_sig_Completed   = r_completed;
  assign o_sig_Time_Out    = r_time_out;
  assign o_op_Conflict     = r_conflict;
  assign o_phase           = r_state;

endmodule

// File: tb/tb_wm_phase_timer.sv
// tb/tb_wm_phase_timer.sv - scoreboard bench for wm_phase_timer
// Expected phase/pulse records are queued at stimulus time and popped by a monitor.
module tb_wm_phase_timer;

  localparam int DEB   = 4;
  localparam int WASH  = 40;
  localparam int RINSE = 25;
  localparam int SPIN  = 17;
  localparam int TO    = 60;

  localparam bit [4:0] OP_NONE  = 5'b00000;
  localparam bit [4:0] OP_FILL  = 5'b00001;
  localparam bit [4:0] OP_HEAT  = 5'b00010;
  localparam bit [4:0] OP_WASH  = 5'b00100;
  localparam bit [4:0] OP_RINSE = 5'b01000;
  localparam bit [4:0] OP_SPIN  = 5'b10000;

  typedef struct {
    int cyc;
    int phase;
    bit conf;
  } ph_t;

  typedef struct {
    int       cyc;
    bit [3:0] kind;
  } pu_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       fill_op, heat_op, wash_op, rinse_op, spin_op;
  logic       level_raw, temp_raw;
  logic       sig_full, sig_temp, sig_comp, sig_to, op_conf;
  logic [2:0] phase;

  ph_t ph_q[$];
  pu_t pu_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  s_edge   = 0;

  int m_op    = 0;
  int m_entry = 0;
  int m_run   = 0;
  bit m_over  = 1'b0;
  int m_phase = 0;

  wm_phase_timer #(
    .CNT_W(16), .DEB_CYCLES(DEB), .WASH_CYCLES(WASH), .RINSE_CYCLES(RINSE),
    .SPIN_CYCLES(SPIN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_fill_Water_Operation(fill_op), .i_heat_Water_Operation(heat_op),
    .i_wash_Operation(wash_op), .i_rinse_Operation(rinse_op), .i_spin_Operation(spin_op),
    .i_level_Raw(level_raw), .i_temp_Raw(temp_raw),
    .o_sig_Full(sig_full), .o_sig_Temperature(sig_temp), .o_sig_Completed(sig_comp),
    .o_sig_Time_Out(sig_to), .o_op_Conflict(op_conf), .o_phase(phase)
  );

  always #5 clk = ~clk;

  task automatic summary_and_finish();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic chk(input string name, input int cyc, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else begin
      $display("FAIL %s edge=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
      if (n_checks - n_pass > 40) summary_and_finish();
    end
  endtask

  // Reference: a phase is identified by the op that started it and its age in
  // edges since entry; pulses fire when the debounce run or the age hits its limit.
  task automatic step(input bit r, input bit [4:0] ops, input bit lvl, input bit tmp);
    int       sel;
    int       age;
    int       dur;
    bit       conf;
    bit       raw;
    bit [3:0] pulses;
    ph_t      pr;
    pu_t      pp;
    rst = r;
    {spin_op, rinse_op, wash_op, heat_op, fill_op} = ops;
    level_raw = lvl;
    temp_raw  = tmp;
    pulses = 4'b0000;
    conf   = 1'b0;
    if (r) begin
      m_op    = 0;
      m_over  = 1'b0;
      m_phase = 0;
    end else begin
      sel = 0;
      for (int b = 4; b >= 0; b--) if (ops[b]) sel = b + 1;
      conf = ($countones(ops) > 1);
      if (sel != m_op) begin
        m_op    = sel;
        m_entry = s_edge;
        m_run   = 0;
        m_over  = 1'b0;
        m_phase = sel;
      end else if (sel != 0 && !m_over) begin
        age = s_edge - m_entry;
        if (sel <= 2) begin
          raw   = (sel == 1) ? lvl : tmp;
          m_run = raw ? m_run + 1 : 0;
          if (m_run >= DEB) begin
            pulses  = (sel == 1) ? 4'b0001 : 4'b0010;
            m_phase = 6;
            m_over  = 1'b1;
          end else if (age >= TO) begin
            pulses  = 4'b1000;
            m_phase = 7;
            m_over  = 1'b1;
          end
        end else begin
          dur = (sel == 3) ? WASH : (sel == 4) ? RINSE : SPIN;
          if (age >= dur) begin
            pulses  = 4'b0100;
            m_phase = 6;
            m_over  = 1'b1;
          end
        end
      end
    end
    pr.cyc = s_edge; pr.phase = m_phase; pr.conf = conf;
    ph_q.push_back(pr);
    if (pulses != 4'b0000) begin
      pp.cyc = s_edge; pp.kind = pulses;
      pu_q.push_back(pp);
    end
    s_edge++;
    @(negedge clk);
  endtask

  task automatic hold(input bit [4:0] ops, input int n, input bit lvl, input bit tmp);
    for (int k = 0; k < n; k++) step(1'b0, ops, lvl, tmp);
  endtask

  always @(posedge clk) begin
    ph_t      pr;
    pu_t      pp;
    bit [3:0] seen;
    #1;
    if (ph_q.size() > 0) begin
      pr = ph_q.pop_front();
      chk("phase", pr.cyc, int'(phase), pr.phase);
      chk("op_conflict", pr.cyc, int'(op_conf), int'(pr.conf));
      while (pu_q.size() > 0 && pu_q[0].cyc < pr.cyc) begin
        pp = pu_q.pop_front();
        chk("missed_pulse", pp.cyc, 0, int'(pp.kind));
      end
      seen = {sig_to, sig_comp, sig_temp, sig_full};
      if (seen != 4'b0000) begin
        if (pu_q.size() > 0 && pu_q[0].cyc == pr.cyc) begin
          pp = pu_q.pop_front();
          chk("pulse_kind", pr.cyc, int'(seen), int'(pp.kind));
        end else begin
          chk("spurious_pulse", pr.cyc, int'(seen), 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog edge=%0d actual=running required=finished", s_edge);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [4:0] ops;
    int       len;
    int       pr;
    int       sel;
    rst = 1'b1;
    {spin_op, rinse_op, wash_op, heat_op, fill_op} = OP_NONE;
    level_raw = 1'b0;
    temp_raw  = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) step(1'b1, OP_NONE, 1'b0, 1'b0);
    hold(OP_NONE, 2, 1'b0, 1'b0);

    // fill with level rising after ten edges
    hold(OP_FILL, 10, 1'b0, 1'b0);
    hold(OP_FILL, 12, 1'b1, 1'b0);
    hold(OP_NONE, 2, 1'b0, 1'b0);

    // heat never reaches temperature
    hold(OP_HEAT, TO + 20, 1'b0, 1'b0);
    hold(OP_NONE, 1, 1'b0, 1'b0);

    // wash, rinse, then wash re-run after an idle gap
    hold(OP_WASH, WASH + 5, 1'b0, 1'b0);
    hold(OP_RINSE, RINSE + 5, 1'b0, 1'b0);
    hold(OP_NONE, 1, 1'b0, 1'b0);
    hold(OP_WASH, WASH + 2, 1'b0, 1'b0);
    hold(OP_NONE, 1, 1'b0, 1'b0);

    // debounce glitch 1,1,0 then stable high
    hold(OP_FILL, 3, 1'b0, 1'b0);
    step(1'b0, OP_FILL, 1'b1, 1'b0);
    step(1'b0, OP_FILL, 1'b1, 1'b0);
    step(1'b0, OP_FILL, 1'b0, 1'b0);
    hold(OP_FILL, 8, 1'b1, 1'b0);
    hold(OP_NONE, 1, 1'b0, 1'b0);

    // conflicting wash and spin
    hold(OP_WASH | OP_SPIN, WASH + 3, 1'b0, 1'b0);
    hold(OP_NONE, 1, 1'b0, 1'b0);

    // reset mid-spin, op held so spin restarts afterwards
    hold(OP_SPIN, 10, 1'b0, 1'b0);
    step(1'b1, OP_SPIN, 1'b0, 1'b0);
    step(1'b1, OP_SPIN, 1'b0, 1'b0);
    hold(OP_SPIN, SPIN + 3, 1'b0, 1'b0);
    hold(OP_NONE, 1, 1'b0, 1'b0);

    // debounce completes on the very time-out edge, then one edge too late
    for (int j = 0; j < TO + 4; j++) step(1'b0, OP_FILL, (j >= TO - DEB + 1), 1'b0);
    hold(OP_NONE, 1, 1'b0, 1'b0);
    for (int j = 0; j < TO + 4; j++) step(1'b0, OP_HEAT, 1'b0, (j >= TO - DEB + 2));
    hold(OP_NONE, 1, 1'b0, 1'b0);

    for (int s = 0; s < 150; s++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      ops = OP_NONE;
      else if (sel == 1) ops = 5'($urandom_range(0, 31));
      else               ops = 5'(1 << $urandom_range(0, 4));
      len = $urandom_range(1, 80);
      pr  = $urandom_range(30, 97);
      if ($urandom_range(0, 29) == 0) begin
        for (int k = 0; k < $urandom_range(1, 2); k++) step(1'b1, ops, 1'b0, 1'b0);
      end
      for (int k = 0; k < len; k++)
        step(1'b0, ops, ($urandom_range(0, 99) < pr), ($urandom_range(0, 99) < pr));
    end

    hold(OP_NONE, 3, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pulse_queue_drained", s_edge, pu_q.size(), 0);
    chk("phase_queue_drained", s_edge, ph_q.size(), 0);
    summary_and_finish();
  end

endmodule
